mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//   Parametrised iterative multiply/divide unit owning the HI/LO register pair.
//   Performs signed/unsigned MUL and DIV over WIDTH cycles using shift-add and restoring division,
//   instead of single-cycle combinational operators.
//   Sits beside the ALU in EX. The pipeline issues an op with start, stalls MFHI/MFLO/MTHI/MTLO
//   while busy, and reads hi/lo directly.
// PARAMETERS
//   WIDTH    32   operand width; HI/LO are each WIDTH bits; product is 2*WIDTH bits
//   CNT_W    $clog2(WIDTH+1)   iteration counter width (derived, not overridden)
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      issue op; accepted only when busy=0
//   op        in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with start)
//   src_a     in   WIDTH  multiplicand / dividend (sampled with start)
//   src_b     in   WIDTH  multiplier / divisor (sampled with start)
//   flush     in   1      abandon in-flight op (pipeline squash)
//   hi_we     in   1      MTHI: write wdata to HI
//   lo_we     in   1      MTLO: write wdata to LO
//   wdata     in   WIDTH  data for hi_we/lo_we
//   busy      out  1      op in flight; start/hi_we/lo_we are ignored while high
//   done      out  1      one-cycle pulse: HI/LO hold the new result
//   div_zero  out  1      valid with done; 1 if a DIV/DIVU had src_b==0
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter=0.
//   FSM: IDLE -> CALC -> FIX -> IDLE.
//   - IDLE: start=1 and flush=0 at edge k latches |a|, |b| (signed ops: magnitude;
//     unsigned: as-is), the result signs, and op. State -> CALC, busy=1 after edge k.
//   - CALC: one shift-add or restoring-subtract step per edge, edges k+1..k+WIDTH.
//     Counter counts WIDTH down to 0.
//   - FIX: at edge k+WIDTH+1, applies the sign correction and writes HI/LO.
//     Sets done=1 and div_zero as applicable. busy=0 and state=IDLE after that edge.
//   - done is high exactly one cycle (cleared at the next edge).
//   Latency: start accepted at edge k -> result visible and done=1 after edge k+WIDTH+1.
//   Arithmetic:
//   - MUL: {HI,LO} = 2*WIDTH-bit product; MULT negates the product if operand signs differ.
//   - DIV: LO=quotient, HI=remainder. For DIV, quotient is negated if signs differ;
//     remainder takes the sign of the dividend (truncating division).
//   - DIV with a=MIN, b=-1: LO=MIN (0x80000000 at 32), HI=0; div_zero=0.
//   - Divide by zero (both DIV and DIVU): LO=all ones, HI=src_a unmodified, div_zero=1.
//     Latency is unchanged (the iteration still runs).
//   Boundary conditions:
//   - start while busy: ignored (no effect on state, operands or HI/LO).
//   - flush while busy: state -> IDLE at next edge; busy=0; HI/LO unchanged; no done pulse.
//     flush in FIX wins over the write.
//   - flush with start in IDLE: flush wins, op not accepted.
//   - hi_we/lo_we: write at the next edge only if busy=0 and start=0; start wins if both asserted.
//     hi_we and lo_we may be asserted together (both written from wdata).
//     Both are ignored while busy.
//   - Back-to-back: start may be asserted in the same cycle done=1 (busy=0); it is accepted.
//   - rst_n low mid-operation: immediate return to reset values; partial result discarded.
// TESTING (WIDTH=32)
//   - MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge 0
//     -> done=1 after edge 33; HI=0xFFFFFFFE, LO=0x00000001; busy high cycles 1..33.
//   - MULT a=-3 b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//     Then MULT a=0x80000000 b=0x80000000 -> HI=0x40000000, LO=0.
//   - DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     DIVU a=7 b=0 -> LO=0xFFFFFFFF, HI=7, div_zero=1.
//     DIV a=0x80000000 b=-1 -> LO=0x80000000, HI=0.
//   - Preload via lo_we wdata=0x1234 -> lo=0x1234.
//     DIVU started, flush at cycle 10 -> busy=0 at cycle 11, no done, lo still 0x1234.
//     start at cycle 5 of a busy op is ignored (result matches first op only).
//   - Assert hi_we wdata=0xABCD while busy -> hi unchanged.
//     Same stimulus in IDLE -> hi=0xABCD next cycle.
//     start+hi_we together in IDLE -> op accepted, hi unchanged.
//   - rst_n pulsed low at cycle 15 of a MULT -> hi=lo=0, busy=0, done=0 immediately.
//     A fresh MULTU 6*7 afterwards -> LO=42, HI=0.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative multiply/divide unit that owns the HI/LO pair.
// MULT/MULTU use one shift-add step per cycle. DIV/DIVU use one restoring-subtract
// step per cycle. Both work on operand magnitudes and fix the signs in a final cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op           issue an op (00 MULTU, 01 MULT, 10 DIVU, 11 DIV); ignored while busy
//   src_a, src_b        multiplicand/dividend and multiplier/divisor, sampled with start
//   flush               abandon the in-flight op without touching HI/LO
//   hi_we, lo_we, wdata MTHI/MTLO writes, honoured only when idle and not starting
//   busy, done          op in flight / one-cycle result-written pulse
//   div_zero            qualifies done: the divide had a zero divisor
//   hi, lo              architectural HI/LO registers
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             step;
    logic             finish;

    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [1:0]       op_q;
    logic             neg_q;
    logic             neg_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes; a flush always wins over issue or writeback
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    state_next = S_CALC;
                    load       = 1'b1;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_next = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
                finish     = !flush;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand magnitudes and signs at issue; op[0] selects the signed variant
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_abs_c;
    logic [WIDTH-1:0] b_abs_c;

    always_comb begin
        a_neg_c = op[0] & src_a[WIDTH-1];
        b_neg_c = op[0] & src_b[WIDTH-1];
        a_abs_c = a_neg_c ? -src_a : src_a;
        b_abs_c = b_neg_c ? -src_b : src_b;
    end

    // One iteration step.
    // Multiply: acc = {partial sum, remaining multiplier bits}.
    // Divide: acc = {partial remainder, dividend bits shifting into the quotient}.
    logic [WIDTH:0]   add_sum_c;
    logic [PW-1:0]    mul_next_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   trial_c;
    logic [PW-1:0]    div_next_c;

    always_comb begin
        add_sum_c  = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : {(WIDTH + 1){1'b0}});
        mul_next_c = {add_sum_c, acc[WIDTH-1:1]};
        shifted_c  = {acc[PW-1:WIDTH], acc[WIDTH-1]};
        trial_c    = shifted_c - {1'b0, b_mag};
        // The top bit of the trial difference is the borrow: keep the old remainder
        if (trial_c[WIDTH]) begin
            div_next_c = {shifted_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_next_c = {trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign fix-up and final HI/LO values
    logic             b_zero_c;
    logic [PW-1:0]    prod_c;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;

    always_comb begin
        b_zero_c = (b_mag == {WIDTH{1'b0}});
        prod_c   = neg_q ? -acc : acc;
        res_hi_c = prod_c[PW-1:WIDTH];
        res_lo_c = prod_c[WIDTH-1:0];
        if (op_q[1]) begin
            if (b_zero_c) begin
                // Re-negating the magnitude reproduces the raw dividend, including MIN
                res_hi_c = neg_r ? -a_mag : a_mag;
                res_lo_c = {WIDTH{1'b1}};
            end else begin
                res_hi_c = neg_r ? -acc[PW-1:WIDTH] : acc[PW-1:WIDTH];
                res_lo_c = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= {CNT_W{1'b0}};
            acc      <= {PW{1'b0}};
            a_mag    <= {WIDTH{1'b0}};
            b_mag    <= {WIDTH{1'b0}};
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
        end else begin
            busy     <= (state_next != S_IDLE);
            done     <= finish;
            div_zero <= finish & op_q[1] & b_zero_c;

            if (load) begin
                a_mag <= a_abs_c;
                b_mag <= b_abs_c;
                op_q  <= op;
                neg_q <= a_neg_c ^ b_neg_c;
                neg_r <= a_neg_c;
                cnt   <= CNT_W'(WIDTH);
                acc   <= {{WIDTH{1'b0}}, (op[1] ? a_abs_c : b_abs_c)};
            end else if (step) begin
                acc <= op_q[1] ? div_next_c : mul_next_c;
                cnt <= cnt - CNT_W'(1);
            end

            if (finish) begin
                hi <= res_hi_c;
                lo <= res_lo_c;
            end else if (!busy && !start) begin
                if (hi_we) begin
                    hi <= wdata;
                end
                if (lo_we) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit.
// Expected values come from plain 64-bit multiply and truncating divide.
// Directed cases are followed by a run of random back-to-back ops.
module tb_mips_muldiv_unit;
    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one op, computed with ordinary integer arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mh, output logic [31:0] ml, output logic mz);
        logic [63:0] p;
        int          sa;
        int          sb;
        mz = 1'b0;
        mh = '0;
        ml = '0;
        if (o == 2'b00) begin
            p  = 64'(a) * 64'(b);
            mh = p[63:32];
            ml = p[31:0];
        end else if (o == 2'b01) begin
            p  = 64'(longint'($signed(a)) * longint'($signed(b)));
            mh = p[63:32];
            ml = p[31:0];
        end else if (b == 32'd0) begin
            mz = 1'b1;
            mh = a;
            ml = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
            ml = a / b;
            mh = a % b;
        end else if (a == MIN && b == 32'hFFFF_FFFF) begin
            ml = MIN;
            mh = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            ml = 32'(sa / sb);
            mh = 32'(sa % sb);
        end
    endfunction

    // Issue one op, optionally disturb it mid-flight, then wait for and check the result.
    // poke 1: a second start at cycle 5. poke 2: hi_we at cycle 5.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input string tag);
        logic [31:0] mh;
        logic [31:0] ml;
        logic        mz;
        int          lat;
        int          busy_cnt;
        model(o, a, b, mh, ml, mz);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check({tag, "_busy_at_issue"}, 64'(busy), 64'(1));
        check({tag, "_done_low_at_issue"}, 64'(done), 64'(0));
        check({tag, "_hi_kept_at_issue"}, 64'(hi), 64'(exp_hi));
        lat      = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (poke == 1 && n == 5) begin
                start = 1'b1;
                op    = ~o;
                src_a = $urandom;
                src_b = $urandom;
            end
            if (poke == 2 && n == 5) begin
                hi_we = 1'b1;
                wdata = 32'h0000_ABCD;
            end
            tick();
            start = 1'b0;
            hi_we = 1'b0;
            if (poke == 2 && n == 5) begin
                check({tag, "_hi_we_while_busy"}, 64'(hi), 64'(exp_hi));
            end
            if (done) begin
                lat = n;
                break;
            end
            if (busy) begin
                busy_cnt++;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(WIDTH + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
        check({tag, "_busy_low_at_done"}, 64'(busy), 64'(0));
        check({tag, "_hi"}, 64'(hi), 64'(mh));
        check({tag, "_lo"}, 64'(lo), 64'(ml));
        check({tag, "_div_zero"}, 64'(div_zero), 64'(mz));
        exp_hi = mh;
        exp_lo = ml;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        seen;

        #12;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_div_zero", 64'(div_zero), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases, including the boundary values
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_max_lo_const", 64'(lo), 64'h0000_0000_0000_0001);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg3x5");
        run_op(2'b01, MIN, MIN, 0, "mult_minxmin");
        check("mult_minxmin_hi_const", 64'(hi), 64'h0000_0000_4000_0000);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, "div_neg7by2");
        run_op(2'b10, 32'd7, 32'd0, 0, "divu_by0");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 0, "div_neg_by0");
        run_op(2'b11, MIN, 32'hFFFF_FFFF, 0, "div_min_by_m1");
        check("div_min_by_m1_lo_const", 64'(lo), 64'h0000_0000_8000_0000);

        // MTLO preload, then an op squashed mid-flight must leave HI/LO alone
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        lo_we  = 1'b0;
        exp_lo = 32'h0000_1234;
        check("mtlo_preload", 64'(lo), 64'(exp_lo));
        op    = 2'b10;
        src_a = 32'd100;
        src_b = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_low", 64'(busy), 64'(0));
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= done;
        end
        check("flush_no_done", 64'(seen), 64'(0));
        check("flush_lo_kept", 64'(lo), 64'(exp_lo));
        check("flush_hi_kept", 64'(hi), 64'(exp_hi));

        // Flush in the fix-up cycle beats the writeback
        op    = 2'b00;
        src_a = 32'd1000;
        src_b = 32'd1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (WIDTH) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fix_done", 64'(done), 64'(0));
        check("flush_fix_busy", 64'(busy), 64'(0));
        check("flush_fix_lo", 64'(lo), 64'(exp_lo));

        // Flush together with start in idle: nothing is issued
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_idle_busy", 64'(busy), 64'(0));

        // Start and MTHI while busy are ignored
        run_op(2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1, "start_while_busy");
        run_op(2'b00, 32'd123, 32'd456, 2, "hi_we_busy");

        // MTHI in idle, then start together with MTHI
        hi_we = 1'b1;
        wdata = 32'h0000_ABCD;
        tick();
        hi_we  = 1'b0;
        exp_hi = 32'h0000_ABCD;
        check("mthi_idle", 64'(hi), 64'(exp_hi));
        hi_we = 1'b1;
        wdata = 32'h0000_5555;
        run_op(2'b00, 32'd9, 32'd9, 0, "start_with_hi_we");

        // Random back-to-back ops
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin
                    ra = MIN;
                    rb = 32'hFFFF_FFFF;
                end
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(ro, ra, rb, 0, "random");
        end

        // Reset in the middle of a MULT
        op    = 2'b01;
        src_a = 32'hFFFF_FB2E;
        src_b = 32'd777;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_hi", 64'(hi), 64'(0));
        check("midreset_lo", 64'(lo), 64'(0));
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_done", 64'(done), 64'(0));
        exp_hi = '0;
        exp_lo = '0;
        #2;
        rst_n = 1'b1;
        tick();
        run_op(2'b00, 32'd6, 32'd7, 0, "after_reset");
        check("after_reset_lo_const", 64'(lo), 64'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
